// File: rtl/sntrup_mem_pkg.sv
// Shared constants and types for the SNTRUP757 coefficient memories and their
// read sequencer.
package sntrup_mem_pkg;

    localparam int unsigned RAM_WIDTH     = 26;
    localparam int unsigned RAM_ADDR_BITS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/mem_stream_reader.sv
// Walks addresses 0..deg of a combinational-read RAM and presents each
// coefficient as a registered valid/ready stream with index and last flags.
module mem_stream_reader #(
    parameter int unsigned RAM_WIDTH     = sntrup_mem_pkg::RAM_WIDTH,
    parameter int unsigned RAM_ADDR_BITS = sntrup_mem_pkg::RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] deg_i,
    output logic [RAM_ADDR_BITS-1:0] rd_addr_o,
    input  logic [RAM_WIDTH-1:0]     rd_data_i,
    output logic [RAM_WIDTH-1:0]     out_data_o,
    output logic [RAM_ADDR_BITS-1:0] out_index_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);
    import sntrup_mem_pkg::*;

    rd_state_t                state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [RAM_ADDR_BITS-1:0] deg_q, deg_d;
    logic [RAM_WIDTH-1:0]     data_q, data_d;
    logic [RAM_ADDR_BITS-1:0] index_q, index_d;
    logic                     last_q, last_d;
    logic                     valid_q, valid_d;
    logic                     load;
    logic                     at_end;

    assign at_end = (addr_q == deg_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        deg_d   = deg_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        valid_d = valid_q;
        load    = 1'b0;

        // A consumed beat with nothing to replace it empties the register.
        if (state_q != STREAM && valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    deg_d   = deg_i;
                    addr_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                load = !valid_q || out_ready_i;
                if (load) begin
                    data_d  = rd_data_i;
                    index_d = addr_q;
                    last_d  = at_end;
                    valid_d = 1'b1;
                    // Stop on the compare instead of incrementing, so the
                    // counter never wraps even when deg_q is all ones.
                    if (at_end) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_ready_i) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            deg_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            deg_q   <= deg_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign rd_addr_o   = addr_q;
    assign out_data_o  = data_q;
    assign out_index_o = index_q;
    assign out_last_o  = last_q;
    assign out_valid_o = valid_q;
    assign busy_o      = (state_q == STREAM) || (state_q == DRAIN);
    assign done_o      = (state_q == FINISH);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: RAM model, stream scoreboard, stall,
// degenerate lengths, ignored restart and asynchronous reset mid-stream.
module tb_mem_stream_reader;

    localparam int W = 26;
    localparam int A = 11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [A-1:0] deg_i = '0;
    logic [A-1:0] rd_addr_o;
    logic [W-1:0] rd_data_i;
    logic [W-1:0] out_data_o;
    logic [A-1:0] out_index_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic         out_last_o;
    logic         busy_o;
    logic         done_o;

    logic [W-1:0] mem [2048];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign rd_data_i = mem[rd_addr_o];

    mem_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .deg_i      (deg_i),
        .rd_addr_o  (rd_addr_o),
        .rd_data_i  (rd_data_i),
        .out_data_o (out_data_o),
        .out_index_o(out_index_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o (out_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start_i = 1'b1;
        deg_i   = A'(d);
        tick();
        start_i = 1'b0;
        deg_i   = A'($urandom);
    endtask

    // mode 0: ready always 1; 1: random ready; 2: stall 3 cycles on beat 1;
    // 3: ready 1 plus an extra start with another deg at beat 2.
    // abort_at >= 0 stops the scoreboard after that many accepted beats.
    task automatic run_stream(input int d, input int mode, input int abort_at,
                              input string name);
        int beats = 0;
        int cycles = 0;
        int stall = 0;
        int pulses = 0;
        logic rdy;
        bit seen_busy = 0;
        pulse_start(d);
        while (beats <= d && cycles < 3 * d + 100) begin
            if (abort_at >= 0 && beats == abort_at) break;
            case (mode)
                1: rdy = 1'($urandom);
                2: begin
                    rdy = !(beats == 1 && out_valid_o && stall < 3);
                    if (!rdy) stall++;
                end
                default: rdy = 1'b1;
            endcase
            out_ready_i = rdy;
            start_i = (mode == 3 && beats == 2);
            deg_i   = (mode == 3 && beats == 2) ? A'(d + 5) : deg_i;
            if (busy_o) seen_busy = 1;
            #4;
            if (out_valid_o) begin
                total++;
                if (out_index_o !== A'(beats) || out_data_o !== mem[beats]
                    || out_last_o !== (beats == d)) begin
                    bad++;
                    $display("FAIL %s beat: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                             name, out_index_o, out_data_o, out_last_o, beats, mem[beats],
                             (beats == d));
                end
                if (mode == 2 && !rdy) begin
                    total++;
                    if (rd_addr_o !== A'(2)) begin
                        bad++;
                        $display("FAIL %s stall rd_addr: got %0d, required 2", name, rd_addr_o);
                    end
                end
                if (rdy) beats++;
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cycles++;
        end
        if (abort_at >= 0) return;
        out_ready_i = 1'b1;
        total++;
        if (beats != d + 1) begin
            bad++;
            $display("FAIL %s beat count: got %0d, required %0d", name, beats, d + 1);
        end
        total++;
        if (!seen_busy) begin
            bad++;
            $display("FAIL %s busy: got never high, required high during stream", name);
        end
        for (int i = 0; i < 6; i++) begin
            #4;
            if (done_o) pulses++;
            total++;
            if (out_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL %s extra beat: valid=%b idx=%0d, required valid=0",
                         name, out_valid_o, out_index_o);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL %s done pulses: got %0d, required 1", name, pulses);
        end
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle after done: busy=%b done=%b, required 0 0",
                     name, busy_o, done_o);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || out_data_o !== '0
            || out_index_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || rd_addr_o !== '0) begin
            bad++;
            $display("FAIL %s: v=%b l=%b d=%h i=%0d busy=%b done=%b addr=%0d, required all 0",
                     name, out_valid_o, out_last_o, out_data_o, out_index_o, busy_o, done_o,
                     rd_addr_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        check_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_zero("after release");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 2048; i++) mem[i] = W'(i + 100);
        run_stream(3, 0, -1, "deg3");
    endtask

    task automatic test_stall();
        run_stream(3, 2, -1, "stall");
    endtask

    task automatic test_deg_zero();
        mem[0] = 26'h3FFFFFF;
        run_stream(0, 0, -1, "deg0");
    endtask

    task automatic test_full();
        for (int i = 0; i < 2048; i++) mem[i] = W'($urandom);
        run_stream(2047, 1, -1, "deg2047");
    endtask

    task automatic test_restart_ignored();
        run_stream(6, 3, -1, "restart");
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        for (int i = 0; i < 16; i++) mem[i] = W'(i * 7 + 3);
        run_stream(10, 0, 5, "abort");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid-stream reset");
        for (int i = 0; i < 4; i++) begin
            if (done_o) pulses++;
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done_o) pulses++;
            tick();
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort done: got %0d pulses, required 0", pulses);
        end
        run_stream(3, 0, -1, "after reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_deg_zero();
        test_full();
        test_restart_ignored();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
